// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and their buffers.
package uart_pkg;

  // Width of one serial character as delivered by uart_rx / taken by uart_tx.
  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port and
// one asynchronous read port so the head entry is available combinationally.
module uart_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are intentionally not reset; the pointers decide what is valid.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Write the addressed entry when the FIFO accepts a byte.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Head-of-queue read is purely combinational (first-word fall-through).
  assign rdata = mem_reg[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind uart_rx. Every rx strobe is captured unless
// the buffer is full and nothing leaves in the same cycle; such bytes are
// dropped and a sticky overflow flag is raised, since uart_rx cannot stall.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;

  logic              empty;
  logic              full_int;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head_data;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full_int = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                    (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

  // No handshake is offered while reset is asserted, so a consumer never
  // believes it took a byte that reset is about to discard.
  assign out_valid = !empty && !reset;
  assign pop       = out_valid && out_ready;

  // A full buffer can still take a byte when the head leaves in the same cycle.
  assign push = !reset && in_valid && (!full_int || pop);
  assign drop = !reset && in_valid && full_int && !pop;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr_reg[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_reg[ADDR_W-1:0]),
    .rdata (head_data)
  );

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + PTR_ONE;
      2'b01:   count_next = count_reg - PTR_ONE;
      default: count_next = count_reg;
    endcase

    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clear_overflow) begin
      overflow_next = 1'b0;
    end
  end

  // State registers; reset discards every buffered byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign out_data = out_valid ? head_data : '0;
  assign count    = count_reg;
  assign full     = full_int;
  assign overflow = overflow_reg;

endmodule : uart_rx_fifo
